seq_addsub_ctrl: RTL and testbench

//  Multi-cycle signed add/subtract controller. Reuses one 4-bit ripple-carry add/sub

---
 rtl/seq_addsub_ctrl.sv | 77 +++++++
 tb/tb_seq_addsub_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_ctrl.sv
// seq_addsub_ctrl: nibble-serial signed add/sub controller sharing one 4-bit slice.
// Define SEQ_ADDSUB_SAT_EN to saturate overflowed results to the W-bit signed extreme.
module seq_addsub_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result,
  output logic         overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic carry, op_q, c_msb, cout, ovf, last, accept;
  logic [W-1:0] a_q, b_q, shadow;
  logic [3:0] na, nb, sum, low;
  logic [4:0] full;
  logic [W:0] commit;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    na = a_q[{idx, 2'b00} +: 4];
    nb = b_q[{idx, 2'b00} +: 4] ^ {4{op_q}};
    low = {1'b0, na[2:0]} + {1'b0, nb[2:0]} + {3'b0, carry};
    full = {1'b0, na} + {1'b0, nb} + {4'b0, carry};
    sum = full[3:0];
    cout = full[4];
    c_msb = low[3];
    ovf = c_msb ^ cout;
    last = idx == IW'(NIBBLES - 1);
    accept = start && state != RUN;
    busy = state == RUN;
    done = state == DONE;
    state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
`ifdef SEQ_ADDSUB_SAT_EN
    // an overflowed sum has the wrong sign bit, so sum[3]=1 means the true value is positive
    commit = ovf ? (sum[3] ? {2'b00, {(W-1){1'b1}}} : {2'b11, {(W-1){1'b0}}})
                 : {sum[3], sum, shadow[W-5:0]};
`else
    commit = {ovf ^ sum[3], sum, shadow[W-5:0]};
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      shadow <= '0;
      result <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      op_q <= op_sub;
      carry <= op_sub;
      idx <= '0;
    end else if (state == RUN) begin
      carry <= cout;
      idx <= idx + IW'(1);
      shadow[{idx, 2'b00} +: 4] <= sum;
      if (last) begin
        result <= commit;
        overflow <= ovf;
      end
    end
endmodule

// File: tb/tb_seq_addsub_ctrl.sv
// tb_seq_addsub_ctrl: table, corner-sequence and random checks of seq_addsub_ctrl (NIBBLES=4).
module tb_seq_addsub_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset, start, op_sub, busy, done, overflow;
  logic [15:0] a, b;
  logic [16:0] result;
  logic [16:0] prev_res;
  logic prev_ovf;
  int errs = 0, checks = 0;

  typedef struct {
    logic        op;
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] res;
    logic        ovf;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  seq_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model(input logic op, input logic [15:0] x, input logic [15:0] y);
    int sx, sy, r;
    logic o;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r = op ? sx - sy : sx + sy;
    o = (r > 32767) || (r < -32768);
`ifdef SEQ_ADDSUB_SAT_EN
    if (o) r = (r > 0) ? 32767 : -32768;
`endif
    return {o, r[16:0]};
  endfunction

  task automatic run_op(input logic op, input logic [15:0] x, input logic [15:0] y,
                        input logic [16:0] er, input logic eo, input string nm);
    int lat, bc;
    logic stable;
    start = 1'b1; op_sub = op; a = x; b = y;
    step();
    start = 1'b0; op_sub = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 0; bc = 0; stable = 1'b1;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if (result !== prev_res || overflow !== prev_ovf) stable = 1'b0;
      step();
      lat++;
    end
    chk({nm, " latency"}, lat, N);
    chk({nm, " busy cycles"}, bc, N);
    chk({nm, " held during run"}, {31'b0, stable}, 1);
    chk({nm, " result"}, {15'b0, result}, {15'b0, er});
    chk({nm, " overflow"}, {31'b0, overflow}, {31'b0, eo});
    prev_res = er; prev_ovf = eo;
    step();
    chk({nm, " done pulse width"}, {31'b0, done}, 0);
  endtask

  initial begin
    logic [17:0] m;
    logic [32:0] e;
    logic [32:0] q[$];
    logic [15:0] x, y;
    logic op;
    int bc, dc;
    vecs[0] = '{1'b0, 16'h1234, 16'h0FED, 17'h02221, 1'b0};
    vecs[2] = '{1'b1, 16'h0000, 16'h0001, 17'h1FFFF, 1'b0};
    vecs[6] = '{1'b0, 16'hFFFF, 16'h0001, 17'h00000, 1'b0};
`ifdef SEQ_ADDSUB_SAT_EN
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 17'h07FFF, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 17'h18000, 1'b1};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 17'h18000, 1'b1};
    vecs[5] = '{1'b1, 16'h7FFF, 16'h8000, 17'h07FFF, 1'b1};
`else
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 17'h17FFF, 1'b1};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b1};
    vecs[5] = '{1'b1, 16'h7FFF, 16'h8000, 17'h0FFFF, 1'b1};
`endif
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    prev_res = '0; prev_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset result", {15'b0, result}, 0);
    chk("reset overflow", {31'b0, overflow}, 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].ovf, $sformatf("vec%0d", i));
    // a second start two cycles into RUN must be ignored
    m = model(1'b0, 16'h1111, 16'h2222);
    start = 1'b1; op_sub = 1'b0; a = 16'h1111; b = 16'h2222;
    step();
    start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        chk("ignored start result", {15'b0, result}, {15'b0, m[16:0]});
      end
      if (i == 2) begin start = 1'b1; op_sub = 1'b1; a = 16'h7000; b = 16'h0123; end
      if (i == 3) start = 1'b0;
      step();
    end
    chk("ignored start busy cycles", bc, N);
    chk("ignored start done count", dc, 1);
    // reset in RUN cycle 2 aborts without a done pulse
    start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h0FED;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort done", {31'b0, done}, 0);
    chk("abort result", {15'b0, result}, 0);
    chk("abort overflow", {31'b0, overflow}, 0);
    step();
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dc++;
      step();
    end
    chk("abort no done", dc, 0);
    prev_res = '0; prev_ovf = 1'b0;
    run_op(1'b0, 16'h0001, 16'h0001, 17'h00002, 1'b0, "post reset");
    // start held high: each op uses the operands present at its accepting edge
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      op_sub = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      if (c % 5 == 0) q.push_back({op_sub, a, b});
      step();
      chk("stream done", {31'b0, done}, (c % 5 == 4) ? 1 : 0);
      if (c % 5 == 4 && q.size() > 0) begin
        e = q.pop_front();
        m = model(e[32], e[31:16], e[15:0]);
        chk("stream result", {15'b0, result}, {15'b0, m[16:0]});
        chk("stream overflow", {31'b0, overflow}, {31'b0, m[17]});
        prev_res = m[16:0]; prev_ovf = m[17];
      end
    end
    start = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      op = 1'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x = {x[0], {15{~x[0]}}};
      if ($urandom_range(0, 3) == 0) y = {y[0], {15{~y[0]}}};
      m = model(op, x, y);
      run_op(op, x, y, m[16:0], m[17], $sformatf("rand%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
